// File: rtl/rs_scheduler.sv
// rtl/rs_scheduler.sv - reservation station: tag wakeup, oldest-ready select, single-issue handshake
// Optional macro RS_WAKEUP_BYPASS_EN: zero-cycle wakeup-to-issue via CDB forwarding.
module rs_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9:0]      in_Op,
  input  logic [TAGW-1:0] in_Qj,
  input  logic [TAGW-1:0] in_Qk,
  input  logic [31:0]     in_Vj,
  input  logic [31:0]     in_Vk,
  input  logic [TAGW-1:0] in_Dest,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [31:0]     cdb_value,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [9:0]      issue_Op,
  output logic [31:0]     issue_Vj,
  output logic [31:0]     issue_Vk,
  output logic [TAGW-1:0] issue_Dest,
  output logic [CW-1:0]   count
);

  logic [DEPTH-1:0] r_busy;
  logic [9:0]       r_op   [DEPTH];
  logic [TAGW-1:0]  r_qj   [DEPTH];
  logic [TAGW-1:0]  r_qk   [DEPTH];
  logic [31:0]      r_vj   [DEPTH];
  logic [31:0]      r_vk   [DEPTH];
  logic [TAGW-1:0]  r_dest [DEPTH];
  logic [CW-1:0]    r_age  [DEPTH];
  logic [CW-1:0]    r_count;

  logic             w_cdb_hit;
  logic [DEPTH-1:0] w_ready;
  logic             w_sel_valid;
  logic [IW-1:0]    w_sel_idx;
  logic [CW-1:0]    w_sel_rank;
  logic [IW-1:0]    w_free_idx;
  logic             w_disp;
  logic             w_issue;

  assign w_cdb_hit = cdb_valid && (cdb_tag != '0);
  assign in_ready  = (r_count < CW'(DEPTH));
  assign count     = r_count;
  assign w_disp    = in_valid && in_ready;
  assign w_issue   = w_sel_valid && issue_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      w_ready[i] = r_busy[i]
                && ((r_qj[i] == '0) || (w_cdb_hit && r_qj[i] == cdb_tag))
                && ((r_qk[i] == '0) || (w_cdb_hit && r_qk[i] == cdb_tag));
`else
      w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
`endif
    end
  end

  // Lower age rank means older; ranks of busy entries are always distinct.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_sel_rank  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ready[i] && (!w_sel_valid || r_age[i] < w_sel_rank)) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IW'(i);
        w_sel_rank  = r_age[i];
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IW'(i);
    end
  end

  always_comb begin
    issue_valid = w_sel_valid;
    issue_Op    = '0;
    issue_Vj    = '0;
    issue_Vk    = '0;
    issue_Dest  = '0;
    if (w_sel_valid) begin
      issue_Op   = r_op[w_sel_idx];
      issue_Vj   = r_vj[w_sel_idx];
      issue_Vk   = r_vk[w_sel_idx];
      issue_Dest = r_dest[w_sel_idx];
`ifdef RS_WAKEUP_BYPASS_EN
      if (r_qj[w_sel_idx] != '0) issue_Vj = cdb_value;
      if (r_qk[w_sel_idx] != '0) issue_Vk = cdb_value;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_dest[i] <= '0;
        r_age[i]  <= '0;
      end
    end else if (flush) begin
      r_busy  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i]) begin
          if (w_cdb_hit && r_qj[i] == cdb_tag) begin
            r_qj[i] <= '0;
            r_vj[i] <= cdb_value;
          end
          if (w_cdb_hit && r_qk[i] == cdb_tag) begin
            r_qk[i] <= '0;
            r_vk[i] <= cdb_value;
          end
          if (w_issue && r_age[i] > w_sel_rank) r_age[i] <= r_age[i] - 1'b1;
        end
      end
      if (w_issue) r_busy[w_sel_idx] <= 1'b0;
      if (w_disp) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= in_Op;
        r_dest[w_free_idx] <= in_Dest;
        r_age[w_free_idx]  <= r_count - CW'(w_issue);
        if (w_cdb_hit && in_Qj == cdb_tag) begin
          r_qj[w_free_idx] <= '0;
          r_vj[w_free_idx] <= cdb_value;
        end else begin
          r_qj[w_free_idx] <= in_Qj;
          r_vj[w_free_idx] <= in_Vj;
        end
        if (w_cdb_hit && in_Qk == cdb_tag) begin
          r_qk[w_free_idx] <= '0;
          r_vk[w_free_idx] <= cdb_value;
        end else begin
          r_qk[w_free_idx] <= in_Qk;
          r_vk[w_free_idx] <= in_Vk;
        end
      end
      if (w_disp && !w_issue) r_count <= r_count + 1'b1;
      else if (!w_disp && w_issue) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: doc/rs_scheduler.md
RS_SCHEDULER -- requirements
Module: rs_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: number of reservation-station entries, 2..8.
REQ-002 Parameter TAGW, default 5: operand/destination tag width; tag 0 means "no producer, value valid".
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  discard all entries (branch mispredict).
REQ-007 in_valid  in  1  decoded instruction offered.
REQ-008 in_ready  out  1  an entry is free.
REQ-009 in_Op  in  10  {funct3,funct7} opcode field.
REQ-010 in_Qj, in_Qk  in  TAGW  producer tags of operands j/k.
REQ-011 in_Vj, in_Vk  in  32  operand values, meaningful when the matching tag is 0.
REQ-012 in_Dest  in  TAGW  result tag of the instruction.
REQ-013 cdb_valid  in  1  common-data-bus broadcast valid.
REQ-014 cdb_tag  in  TAGW  broadcast producer tag.
REQ-015 cdb_value  in  32  broadcast result.
REQ-016 issue_valid  out  1  a ready entry is presented to the functional unit.
REQ-017 issue_ready  in  1  functional unit accepts.
REQ-018 issue_Op  out  10; issue_Vj, issue_Vk  out  32; issue_Dest  out  TAGW: issued instruction fields.
REQ-019 count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-020 Entry holds busy, Op, Qj, Qk, Vj, Vk, Dest and an age rank; ready = busy && Qj==0 && Qk==0.
REQ-021 in_ready SHALL be 1 iff count < DEPTH; a slot freed by issue in cycle N is reusable from cycle N+1 only.
REQ-022 Dispatch: in_valid && in_ready at an edge writes the lowest-index free entry, marked youngest.
REQ-023 Wakeup: on cdb_valid with cdb_tag!=0, every busy entry with Qj==cdb_tag (Qk==cdb_tag) SHALL load Vj (Vk) with cdb_value and clear Qj (Qk) at that edge.
REQ-024 Dispatch-cycle capture: an instruction dispatched in the same cycle as a matching broadcast SHALL store cdb_value and a zero tag; both operands may match.
REQ-025 cdb_valid with cdb_tag==0 SHALL have no effect.
REQ-026 Select: issue_valid SHALL be 1 iff any entry is ready; the presented entry is the oldest ready one, outputs combinational from entry state.
REQ-027 Handshake: issue_valid && issue_ready frees the presented entry at that edge; with issue_ready low, outputs SHALL stay stable unless an older entry becomes ready.
REQ-028 count SHALL rise by 1 on dispatch, fall by 1 on issue, and stay unchanged when both occur in one cycle.
REQ-029 Age ranks SHALL remain a strict total order over busy entries; freeing an entry leaves relative order of others unchanged.
REQ-030 flush SHALL clear all busy bits at the next edge, overriding dispatch, wakeup and issue in that cycle; issue_valid is not gated by flush in the flush cycle.
REQ-031 Unused outputs when issue_valid=0 SHALL be driven 0.

Reset
REQ-032 rst_n low SHALL immediately clear all busy bits and age ranks, forcing in_ready=1, issue_valid=0, count=0, issue_* data 0.
REQ-033 Reset asserted mid-handshake SHALL discard the entry without issue; first dispatch is accepted at the first edge after rst_n rises.

Configuration
REQ-034 Macro RS_WAKEUP_BYPASS_EN defined: an entry whose last pending operand matches the current broadcast is treated as ready that cycle, with cdb_value forwarded onto issue_Vj/issue_Vk (wakeup-to-issue latency 0 cycles).
REQ-035 Macro undefined: readiness uses registered state only; an entry woken at edge N can issue no earlier than the cycle following edge N (latency 1 cycle).

Verification
REQ-036 Dispatch Qj=0,Qk=0,Vj=5,Vk=7,Dest=3 with issue_ready=1 -> next cycle issue_valid=1, Vj=5, Vk=7, Dest=3; count 1 -> 0 after accept.
REQ-037 Dispatch A (Qj=4) then B (ready); broadcast tag 4 value 0x1234 -> B issues first, A issues next with Vj=0x1234.
REQ-038 Fill DEPTH=4 with issue_ready=0 -> in_ready=0, count=4; fifth in_valid ignored; one accept -> in_ready=1 next cycle.
REQ-039 Dispatch Qj=6,Qk=6 in same cycle as cdb tag 6 value 0xAA -> entry stored Vj=Vk=0xAA, issues next cycle.
REQ-040 Three entries busy, assert flush with simultaneous dispatch -> count=0, issue_valid=0 next cycle, dispatched entry dropped.
REQ-041 Entry waiting on tag 9, broadcast tag 9 value 0x55 with issue_ready=1 -> issue in broadcast cycle with Vj=0x55 iff RS_WAKEUP_BYPASS_EN, else one cycle later.
